uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel UART receive stage: the consumer of the transmitter's TxD line. Recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) at a fixed clock-per-bit rate using a two-flop synchronizer and mid-bit sampling. It presents each byte on a valid/ready holding register and flags framing and overrun errors. Sits between the serial pin and the byte-oriented consumer logic.

## Interface
- CLKS_PER_BIT, 10416, clock cycles per bit period; must be ≥ 4 (10416 gives 9600 baud at 100 MHz).
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high.
- rxd  input  1  asynchronous serial line; idle high.
- rx_ready  input  1  consumer accepts rx_data when high with rx_valid.
- rx_data  output  8  received byte; reset 0x00.
- rx_valid  output  1  rx_data holds an unconsumed byte; reset 0.
- frame_err  output  1  one-cycle pulse: stop bit sampled low; reset 0.
- overrun  output  1  one-cycle pulse: byte dropped because the holding register was full; reset 0.
- parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 without UART_RX_PARITY_EN; reset 0.
- busy  output  1  high in every state except IDLE; reset 0.

## Operation
- Synchronizer: rxd passes through two flops (both reset to 1), giving rx_s. All decisions use rx_s only.
- Bit counter width: $clog2(CLKS_PER_BIT). HALF = CLKS_PER_BIT/2, integer division.
- States: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_IDLE.
- IDLE: rx_s == 0 → START; counter cleared.
- START: after HALF cycles, sample rx_s. 0 → DATA with bit index 0. 1 → IDLE (false start, no flag).
- DATA: every CLKS_PER_BIT cycles, sample rx_s into shift register bit[index], LSB first. After index 7 → PARITY (macro) or STOP.
- PARITY: after CLKS_PER_BIT cycles, sample the parity bit (even parity: XOR of data bits must equal the sampled bit) → STOP.
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - Sample 1 with no parity error: deliver the byte, then → IDLE.
  - Sample 0: frame_err pulses, byte discarded, → WAIT_IDLE.
  - Parity error: parity_err pulses, byte discarded. Next state is IDLE if the stop bit is 1, WAIT_IDLE if it is 0.
  - A frame with both errors pulses both flags.
- WAIT_IDLE: stays until rx_s == 1, then → IDLE. This prevents re-triggering on a held-low or break line.
- Delivery, evaluated in the delivery cycle:
  - rx_valid == 0, or rx_valid == 1 with rx_ready == 1: load rx_data and set rx_valid = 1.
  - rx_valid == 1 with rx_ready == 0: keep the old byte and pulse overrun.
- Consumption: rx_valid && rx_ready with no delivery in the same cycle clears rx_valid next cycle. rx_data holds its last value.
- Reset mid-frame: returns to IDLE, clears the counter, bit index, shift register and all outputs, and sets the synchronizer to 1.

## Timing
- Let T be the first cycle rx_s == 0 in IDLE. T is 2 cycles after rxd falls, at the clock edge.
- Start sample at T+HALF.
- Data bit i sampled at T+HALF+(i+1)·CLKS_PER_BIT.
- Parity sample at T+HALF+9·CLKS_PER_BIT (macro only).
- Stop sample at T+HALF+9·CLKS_PER_BIT without the macro, T+HALF+10·CLKS_PER_BIT with it.
- rx_valid, frame_err, parity_err and overrun become visible in the cycle after the stop sample.
- IDLE is re-entered in that same cycle, so a new start edge is accepted immediately. Back-to-back frames lose no bits.
- busy rises the cycle after T. It falls in the cycle after the stop sample, or when WAIT_IDLE exits.

## Configuration
- UART_RX_PARITY_EN defined: the frame is 11 bits (start, 8 data, even parity, stop), the PARITY state exists and parity_err is live.
- UART_RX_PARITY_EN undefined: 8N1 frames only, no PARITY state, parity_err tied to 0.

## Test plan
All scenarios use CLKS_PER_BIT=16 and ideal 16-cycle bit periods.
- Frame 0xA5 with rx_ready=1: rx_data=0xA5 and rx_valid=1 for one cycle, starting the cycle after the stop sample. frame_err and overrun stay 0.
- rxd low for 5 cycles, then high: no rx_valid and no errors. busy drops the cycle after the start sample (T+8).
- Frame 0x3C with the stop bit driven 0, held low for 40 further cycles: frame_err pulses once and rx_valid stays 0. busy stays high until rxd returns high plus 2 synchronizer cycles. A following 0x7E frame is received correctly.
- Back-to-back frames 0x11 then 0x22 with rx_ready=0: rx_data stays 0x11, rx_valid stays 1, and overrun pulses once at the second delivery. Raising rx_ready clears rx_valid the next cycle.
- Reset asserted after 4 data bits of 0xFF: all outputs return to reset values. A subsequent frame 0x5A yields rx_data=0x5A.
- With UART_RX_PARITY_EN defined, frame 0x07 carrying parity bit 0 (correct bit is 1): parity_err pulses and rx_valid stays 0. The same frame with parity bit 1 delivers 0x07.

Source files
------------

// File: rtl/uart_receiver.sv
// UART receive stage: 8N1 frames (8E1 when UART_RX_PARITY_EN is defined), mid-bit sampling,
// valid/ready holding register with framing, overrun and parity error pulses.
module uart_receiver #(
   parameter int CLKS_PER_BIT = 10416
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   input  logic       rx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       overrun,
   output logic       parity_err,
   output logic       busy
);

   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam int HALF = CLKS_PER_BIT / 2;
   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   state_t        state, state_nxt;
   logic          rx_meta, rx_s;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [2:0]    bit_idx, bit_idx_nxt;
   logic [7:0]    shift, shift_nxt;
   logic          deliver;
   logic          frame_err_nxt;
   logic          tick_half, tick_full;
`ifdef UART_RX_PARITY_EN
   logic          par_bad, par_bad_nxt;
   logic          parity_err_nxt;
`endif

   assign tick_half = (cnt == HALF_M1);
   assign tick_full = (cnt == FULL_M1);
   assign busy      = (state != S_IDLE);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         state   <= S_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
`ifdef UART_RX_PARITY_EN
         par_bad <= 1'b0;
`endif
      end else begin
         rx_meta <= rxd;
         rx_s    <= rx_meta;
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_idx <= bit_idx_nxt;
         shift   <= shift_nxt;
`ifdef UART_RX_PARITY_EN
         par_bad <= par_bad_nxt;
`endif
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt + CW'(1);
      bit_idx_nxt   = bit_idx;
      shift_nxt     = shift;
      deliver       = 1'b0;
      frame_err_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_nxt    = par_bad;
      parity_err_nxt = 1'b0;
`endif
      unique case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            if (!rx_s) state_nxt = S_START;
         end
         S_START: begin
            if (tick_half) begin
               cnt_nxt = '0;
               if (rx_s) begin
                  state_nxt = S_IDLE;
               end else begin
                  state_nxt   = S_DATA;
                  bit_idx_nxt = '0;
               end
            end
         end
         S_DATA: begin
            if (tick_full) begin
               cnt_nxt            = '0;
               shift_nxt[bit_idx] = rx_s;
               if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_nxt = S_PARITY;
`else
                  state_nxt = S_STOP;
`endif
               end else begin
                  bit_idx_nxt = bit_idx + 3'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (tick_full) begin
               cnt_nxt     = '0;
               par_bad_nxt = (rx_s != ^shift);
               state_nxt   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (tick_full) begin
               cnt_nxt       = '0;
               frame_err_nxt = !rx_s;
`ifdef UART_RX_PARITY_EN
               parity_err_nxt = par_bad;
               deliver        = rx_s && !par_bad;
`else
               deliver        = rx_s;
`endif
               // A low stop bit may be a break; wait for the line to recover before rearming.
               state_nxt = rx_s ? S_IDLE : S_WAIT_IDLE;
            end
         end
         S_WAIT_IDLE: begin
            cnt_nxt = '0;
            if (rx_s) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= frame_err_nxt;
         overrun   <= deliver && rx_valid && !rx_ready;
         if (deliver && !(rx_valid && !rx_ready)) begin
            rx_data  <= shift;
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk) begin
      if (reset) parity_err <= 1'b0;
      else       parity_err <= parity_err_nxt;
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: per-cycle comparison against a frame-level
// scoreboard of expected deliveries, error pulses and busy windows.
module tb_uart_receiver;

   localparam int CPB  = 16;
   localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
   localparam int NB = 10;
`else
   localparam int NB = 9;
`endif

   logic       clk = 1'b0;
   logic       reset, rxd, rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, overrun, parity_err, busy;

   always #5 clk = ~clk;

   uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .reset      (reset),
      .rxd        (rxd),
      .rx_ready   (rx_ready),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .parity_err (parity_err),
      .busy       (busy)
   );

   int cyc      = 0;
   int n_checks = 0;
   int n_errors = 0;

   // Scoreboard: events keyed by the clock edge after which they must be visible.
   logic [7:0] ev_deliver [int];
   bit         ev_ferr    [int];
   bit         ev_perr    [int];
   bit         busy_at    [int];
   bit         m_valid    = 1'b0;
   logic [7:0] m_data     = 8'h00;
   bit         rand_ready = 1'b0;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] want);
      n_checks++;
      assert (obs === want) else begin
         n_errors++;
         $error("FAIL %s @cycle %0d: observed %h expected %h", tag, cyc, obs, want);
      end
   endtask

   task automatic step();
      bit rdy, rst_e, ovr;
      rdy   = rx_ready;
      rst_e = reset;
      @(posedge clk);
      cyc++;
      #1;
      ovr = 1'b0;
      if (rst_e) begin
         m_valid = 1'b0;
         m_data  = 8'h00;
         ev_deliver.delete();
         ev_ferr.delete();
         ev_perr.delete();
         busy_at.delete();
      end else if (ev_deliver.exists(cyc)) begin
         if (m_valid && !rdy) ovr = 1'b1;
         else begin
            m_valid = 1'b1;
            m_data  = ev_deliver[cyc];
         end
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
      check("rx_valid",   8'(rx_valid),   8'(m_valid));
      check("rx_data",    rx_data,        m_data);
      check("overrun",    8'(overrun),    8'(ovr));
      check("frame_err",  8'(frame_err),  8'(ev_ferr.exists(cyc)));
      check("parity_err", 8'(parity_err), 8'(ev_perr.exists(cyc)));
      check("busy",       8'(busy),       8'(busy_at.exists(cyc)));
      if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   // Drives one frame starting now and records what the receiver must do with it.
   task automatic send_frame(input logic [7:0] data, input bit stop_bit, input bit par_flip,
                             input int extra_low);
      int e0, s, busy_end;
      bit perr;
      e0 = cyc;
      s  = e0 + 3 + HALF + NB * CPB;
`ifdef UART_RX_PARITY_EN
      perr = par_flip;
`else
      perr = 1'b0;
`endif
      if (!stop_bit) ev_ferr[s] = 1'b1;
      if (perr) ev_perr[s] = 1'b1;
      if (stop_bit && !perr) ev_deliver[s] = data;
      busy_end = stop_bit ? s - 1 : e0 + (NB + 1) * CPB + extra_low + 2;
      for (int c = e0 + 3; c <= busy_end; c++) busy_at[c] = 1'b1;

      rxd = 1'b0;
      idle(CPB);
      for (int i = 0; i < 8; i++) begin
         rxd = data[i];
         idle(CPB);
      end
`ifdef UART_RX_PARITY_EN
      rxd = (^data) ^ par_flip;
      idle(CPB);
`endif
      rxd = stop_bit;
      idle(CPB + extra_low);
      rxd = 1'b1;
   endtask

   initial begin
      int         e0;
      logic [7:0] d;
      bit         sb;
      int         xl;

      reset    = 1'b1;
      rxd      = 1'b1;
      rx_ready = 1'b1;
      idle(3);
      reset = 1'b0;
      idle(5);

      // Plain frame, consumer always ready.
      send_frame(8'hA5, 1'b1, 1'b0, 0);
      idle(20);

      // Glitch shorter than half a bit: false start.
      e0 = cyc;
      for (int c = e0 + 3; c <= e0 + 2 + HALF; c++) busy_at[c] = 1'b1;
      rxd = 1'b0;
      idle(5);
      rxd = 1'b1;
      idle(30);

      // Framing error with the line held low afterwards, then a good frame.
      send_frame(8'h3C, 1'b0, 1'b0, 40);
      idle(10);
      send_frame(8'h7E, 1'b1, 1'b0, 0);
      idle(10);

      // Back-to-back frames into a stalled consumer.
      rx_ready = 1'b0;
      send_frame(8'h11, 1'b1, 1'b0, 0);
      send_frame(8'h22, 1'b1, 1'b0, 0);
      idle(5);
      check("overrun_hold_data", rx_data, 8'h11);
      rx_ready = 1'b1;
      idle(3);

      // Reset in the middle of a frame of 0xFF, after four data bits.
      e0 = cyc;
      for (int c = e0 + 3; c <= e0 + 5 * CPB; c++) busy_at[c] = 1'b1;
      rxd = 1'b0;
      idle(CPB);
      rxd = 1'b1;
      idle(4 * CPB);
      reset = 1'b1;
      step();
      reset = 1'b0;
      idle(5);
      send_frame(8'h5A, 1'b1, 1'b0, 0);
      idle(10);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b1, 0);
      idle(10);
      send_frame(8'h07, 1'b1, 1'b0, 0);
      idle(10);
`endif

      // Random bytes, occasional bad stop bits, random consumer back-pressure.
      rand_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         d  = 8'($urandom);
         sb = ($urandom_range(0, 4) != 0);
         xl = sb ? 0 : int'($urandom_range(0, 20));
         send_frame(d, sb, 1'b0, xl);
         idle(sb ? int'($urandom_range(0, 6)) : int'($urandom_range(3, 10)));
      end
      rand_ready = 1'b0;
      rx_ready   = 1'b1;
      idle(10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
